// File: rtl/unidade_mult_div.sv
// rtl/unidade_mult_div.sv - iterative multiply/divide unit with HI/LO result registers
module unidade_mult_div #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [1:0]         operacao,
  input  logic [LARGURA-1:0] operando_rs,
  input  logic [LARGURA-1:0] operando_rt,
  output logic               ocupado,
  output logic               pronto,
  output logic               div_zero,
  output logic [LARGURA-1:0] hi,
  output logic [LARGURA-1:0] lo
);

  typedef enum logic [1:0] {OCIOSO, CALCULA, FINALIZA} estado_t;

  estado_t                estado;
  logic                   eh_div;
  logic                   neg_a;
  logic                   neg_b;
  logic [LARGURA-1:0]     op_b;
  logic [2*LARGURA-1:0]   acc;
  logic [5:0]             contador;

  logic                   sinal_rs;
  logic                   sinal_rt;
  logic [LARGURA-1:0]     mag_rs;
  logic [LARGURA-1:0]     mag_rt;
  logic [LARGURA:0]       soma;
  logic [LARGURA:0]       parcial;
  logic [LARGURA:0]       dif;
  logic [2*LARGURA-1:0]   prox;
  logic [2*LARGURA-1:0]   prod_fin;
  logic [LARGURA-1:0]     quoc_fin;
  logic [LARGURA-1:0]     resto_fin;

  // Operand magnitudes at accept time, one iteration step, and final sign correction
  always_comb begin
    sinal_rs = operacao[0] & operando_rs[LARGURA-1];
    sinal_rt = operacao[0] & operando_rt[LARGURA-1];
    mag_rs   = sinal_rs ? -operando_rs : operando_rs;
    mag_rt   = sinal_rt ? -operando_rt : operando_rt;

    // Multiply: lower half holds the remaining multiplier bits, upper half accumulates
    soma    = {1'b0, acc[2*LARGURA-1:LARGURA]} + {1'b0, (acc[0] ? op_b : {LARGURA{1'b0}})};
    // Divide: remainder shifted left with the next dividend bit; borrow means restore
    parcial = acc[2*LARGURA-1:LARGURA-1];
    dif     = parcial - {1'b0, op_b};

    if (eh_div) begin
      if (dif[LARGURA])
        prox = {parcial[LARGURA-1:0], acc[LARGURA-2:0], 1'b0};
      else
        prox = {dif[LARGURA-1:0], acc[LARGURA-2:0], 1'b1};
    end else begin
      prox = {soma, acc[LARGURA-1:1]};
    end

    prod_fin  = (neg_a ^ neg_b) ? -acc : acc;
    quoc_fin  = (neg_a ^ neg_b) ? -acc[LARGURA-1:0] : acc[LARGURA-1:0];
    resto_fin = neg_a ? -acc[2*LARGURA-1:LARGURA] : acc[2*LARGURA-1:LARGURA];
  end

  // Control FSM with the working register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      hi       <= '0;
      lo       <= '0;
      pronto   <= 1'b0;
      div_zero <= 1'b0;
      ocupado  <= 1'b0;
      contador <= '0;
      acc      <= '0;
      op_b     <= '0;
      eh_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            eh_div   <= operacao[1];
            neg_a    <= sinal_rs;
            neg_b    <= sinal_rt;
            op_b     <= mag_rt;
            contador <= '0;
            ocupado  <= 1'b1;
            if (operacao[1] && (operando_rt == '0)) begin
              // Raw dividend kept so it can be returned unchanged in hi
              acc      <= {{LARGURA{1'b0}}, operando_rs};
              div_zero <= 1'b1;
              estado   <= FINALIZA;
            end else begin
              acc      <= {{LARGURA{1'b0}}, mag_rs};
              div_zero <= 1'b0;
              estado   <= CALCULA;
            end
          end
        end
        CALCULA: begin
          acc      <= prox;
          contador <= contador + 6'd1;
          if (contador == 6'(LARGURA - 1))
            estado <= FINALIZA;
        end
        FINALIZA: begin
          if (div_zero) begin
            hi <= acc[LARGURA-1:0];
            lo <= '1;
          end else if (eh_div) begin
            hi <= resto_fin;
            lo <= quoc_fin;
          end else begin
            hi <= prod_fin[2*LARGURA-1:LARGURA];
            lo <= prod_fin[LARGURA-1:0];
          end
          pronto  <= 1'b1;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_mult_div.sv
// tb/tb_unidade_mult_div.sv - self-checking bench for unidade_mult_div
module tb_unidade_mult_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inicio = 1'b0;
  logic [1:0]  operacao = 2'b00;
  logic [31:0] operando_rs = '0;
  logic [31:0] operando_rt = '0;
  logic        ocupado, pronto, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  unidade_mult_div #(.LARGURA(32)) dut (
    .clock(clock), .reset(reset), .inicio(inicio), .operacao(operacao),
    .operando_rs(operando_rs), .operando_rt(operando_rt),
    .ocupado(ocupado), .pronto(pronto), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: arithmetic result computed at accept, published after the latency
  int          m_rest = 0;
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic        m_dz = 1'b0, m_pronto = 1'b0;

  always @(posedge clock) begin
    logic [63:0] p;
    longint sa, sb, q, r;
    m_pronto = 1'b0;
    if (reset) begin
      m_rest = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
    end else if (m_rest > 0) begin
      m_rest--;
      if (m_rest == 0) begin
        m_hi = r_hi; m_lo = r_lo; m_pronto = 1'b1;
      end
    end else if (inicio) begin
      m_dz = operacao[1] && (operando_rt == 0);
      sa = longint'($signed(operando_rs));
      sb = longint'($signed(operando_rt));
      if (m_dz) p = {operando_rs, 32'hFFFF_FFFF};
      else case (operacao)
        2'b00: p = {32'b0, operando_rs} * {32'b0, operando_rt};
        2'b01: p = 64'(sa * sb);
        2'b10: p = {operando_rs % operando_rt, operando_rs / operando_rt};
        default: begin
          q = sa / sb; r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      endcase
      r_hi = p[63:32]; r_lo = p[31:0];
      m_rest = m_dz ? 1 : 33;
    end
  end

  // Every cycle: DUT outputs against the model
  always @(negedge clock) begin
    if (chk_on) begin
      chk("cyc_ocupado", {63'b0, ocupado}, {63'b0, m_rest > 0});
      chk("cyc_pronto", {63'b0, pronto}, {63'b0, m_pronto});
      chk("cyc_div_zero", {63'b0, div_zero}, {63'b0, m_dz});
      chk("cyc_hi", {32'b0, hi}, {32'b0, m_hi});
      chk("cyc_lo", {32'b0, lo}, {32'b0, m_lo});
    end
  end

  // mode 0 plain, 1 disturb inputs mid-op, 2 reset mid-op
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dz,
                        input int e_lat, input int mode);
    int lat;
    bit got;
    operacao = op; operando_rs = a; operando_rt = b; inicio = 1'b1;
    @(posedge clock); #1;
    inicio = 1'b0;
    chk({nm, "_dz_e0"}, {63'b0, div_zero}, {63'b0, e_dz});
    chk({nm, "_busy_e0"}, {63'b0, ocupado}, 64'd1);
    lat = 0; got = 1'b0;
    while (lat < 50 && !got) begin
      if (mode == 1 && lat == 4) operando_rs = 32'd99;
      if (mode == 1 && lat == 9) begin inicio = 1'b1; operacao = 2'b01; operando_rt = 32'd3; end
      if (mode == 1 && lat == 10) inicio = 1'b0;
      if (mode == 2 && lat == 14) reset = 1'b1;
      if (mode == 2 && lat == 16) begin reset = 1'b0; break; end
      @(posedge clock); lat++; #1;
      if (pronto) got = 1'b1;
    end
    if (mode == 2) begin
      chk({nm, "_no_pronto"}, {63'b0, got}, 64'd0);
      chk({nm, "_hi"}, {32'b0, hi}, 64'd0);
      chk({nm, "_lo"}, {32'b0, lo}, 64'd0);
    end else begin
      chk({nm, "_done"}, {63'b0, got}, 64'd1);
      chk({nm, "_latency"}, 64'(lat), 64'(e_lat));
      chk({nm, "_hi"}, {32'b0, hi}, {32'b0, e_hi});
      chk({nm, "_lo"}, {32'b0, lo}, {32'b0, e_lo});
      chk({nm, "_dz"}, {63'b0, div_zero}, {63'b0, e_dz});
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_on = 1'b1;
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, ocupado}, 64'd0);
    chk("rst_pronto", {63'b0, pronto}, 64'd0);
    chk("rst_dz", {63'b0, div_zero}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 0);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 0);
    run_op("divu_b2b", 2'b10, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 33, 0);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 0);
    run_op("div_negdiv", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run_op("divu_zero", 2'b10, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, 1, 0);
    run_op("multu_clr", 2'b00, 32'd2, 32'd1, 32'd0, 32'd2, 1'b0, 33, 0);
    run_op("div_zero_s", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1, 0);
    run_op("ignore_in", 2'b00, 32'd5, 32'd4, 32'd0, 32'd20, 1'b0, 33, 1);
    run_op("abort", 2'b00, 32'd5, 32'd4, 32'd0, 32'd0, 1'b0, 0, 2);
    run_op("after_rst", 2'b00, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 33, 0);

    repeat (3) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_mult_div.md
UNIDADE_MULT_DIV -- requirements
Module: unidade_mult_div

Interface
REQ-001 The block SHALL have parameter LARGURA, default 32, giving the operand and HI/LO width; all values below assume 32.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port inicio, input, 1 bit: start request.
REQ-005 The block SHALL have port operacao, input, 2 bits: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 The block SHALL have port operando_rs, input, 32 bits: multiplicand or dividend, driven from register-file read_RS.
REQ-007 The block SHALL have port operando_rt, input, 32 bits: multiplier or divisor, driven from register-file read_RT.
REQ-008 The block SHALL have port ocupado, output, 1 bit: operation in progress.
REQ-009 The block SHALL have port pronto, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port div_zero, output, 1 bit: the last accepted divide had operando_rt = 0.
REQ-011 The block SHALL have ports hi and lo, outputs, 32 bits each: result registers, fed to the register-file write path.

Function
REQ-012 The block SHALL implement state machine states OCIOSO, CALCULA and FINALIZA, with ocupado = 1 exactly when the state is not OCIOSO.
REQ-013 In OCIOSO, an edge with inicio = 1 is the accept edge (E0); at E0 the block SHALL latch operacao, operando_rs and operando_rt, and all later input changes SHALL be ignored until the operation completes.
REQ-014 At E0, for signed operations, the block SHALL latch operand magnitudes plus the two sign bits; unsigned operations SHALL use the raw values.
REQ-015 At E0, for a non-divide operation, or a divide with operando_rt nonzero, the block SHALL go to CALCULA with a 6-bit iteration counter = 0 and clear div_zero.
REQ-016 In CALCULA, the block SHALL perform exactly one iteration per edge: shift-add for multiply, restoring shift-subtract for divide, using a 64-bit working register; after 32 iterations (edges E1..E32) it SHALL go to FINALIZA.
REQ-017 In FINALIZA (edge E33), the block SHALL apply sign correction, load hi/lo, set pronto = 1 for one cycle and return to OCIOSO.
REQ-018 Multiply results SHALL be hi = upper 32 bits and lo = lower 32 bits of the 64-bit product; a signed product SHALL be negated when the operand signs differ.
REQ-019 Divide results SHALL be lo = quotient and hi = remainder; a signed quotient SHALL be negated when the signs differ, and the remainder SHALL take the dividend's sign.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000 and hi = 0, with no trap.
REQ-021 A divide with operando_rt = 0 at E0 SHALL skip CALCULA and go to FINALIZA, giving hi = operando_rs, lo = 0xFFFFFFFF, div_zero = 1, and pronto after edge E1.
REQ-022 hi and lo SHALL hold their previous values until the FINALIZA edge.
REQ-023 div_zero SHALL hold its value until the next accept edge.
REQ-024 inicio while ocupado = 1 SHALL be ignored, with no queuing.
REQ-025 inicio in the cycle pronto = 1 SHALL be accepted, since the state is OCIOSO; back-to-back operations are legal.
REQ-026 Latency SHALL be: pronto high in the cycle after E33, or after E1 for divide-by-zero; ocupado high from after E0 through the cycle before pronto.

Reset
REQ-027 While reset = 1 at an edge, the block SHALL enter OCIOSO and set hi = 0, lo = 0, pronto = 0, div_zero = 0, ocupado = 0 and counter = 0; reset SHALL take priority over inicio.
REQ-028 Reset during CALCULA or FINALIZA SHALL abort the operation with no pronto pulse, leave hi/lo = 0, and accept a new inicio on the first edge after reset deasserts.

Verification
REQ-029 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; pronto exactly 33 edges after E0; ocupado high during E1..E33.
REQ-030 MULT -3 x 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; then back-to-back DIVU 9 / 4 issued in the pronto cycle -> lo = 2, hi = 1.
REQ-031 DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-032 DIVU 9 / 0 -> after E1: hi = 9, lo = 0xFFFFFFFF, div_zero = 1, single pronto pulse; the next MULTU 2 x 1 clears div_zero at its E0.
REQ-033 Start MULTU 5 x 4, pulse inicio with different operands at E10, change operando_rs at E5 -> all ignored, result lo = 20, hi = 0.
REQ-034 Start MULTU 5 x 4 and assert reset at E15 -> hi = lo = 0, no pronto pulse; a new MULTU 2 x 2 right after reset -> lo = 4.
